// File: rtl/handshake_constant_seq_if.sv
// -----------------------------------------------------------------------------
// handshake_constant_seq_if
// Handshake bundle for the constant-sequence source: a data-less control
// channel (ctrl_valid/ctrl_ready) in, and a registered data channel
// (outs/outs_last/outs_valid/outs_ready) out.
//
// Signals:
//   ctrl_valid  control token present          (environment -> block)
//   ctrl_ready  control token accepted         (block -> environment)
//   outs        current table entry            (block -> environment)
//   outs_last   outs holds the last table entry(block -> environment)
//   outs_valid  output token present           (block -> environment)
//   outs_ready  consumer accepts output token  (environment -> block)
//
// Modports:
//   slave   - the constant-sequence block itself
//   master  - the surrounding environment (producer of ctrl, consumer of outs)
// -----------------------------------------------------------------------------
interface handshake_constant_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ctrl_valid;
    logic                  ctrl_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_last;
    logic                  outs_valid;
    logic                  outs_ready;

    modport slave (
        input  ctrl_valid,
        output ctrl_ready,
        output outs,
        output outs_last,
        output outs_valid,
        input  outs_ready
    );

    modport master (
        output ctrl_valid,
        input  ctrl_ready,
        input  outs,
        input  outs_last,
        input  outs_valid,
        output outs_ready
    );
endinterface

// File: rtl/handshake_constant_seq.sv
// -----------------------------------------------------------------------------
// handshake_constant_seq
// Elastic constant-sequence source. Every accepted control token loads the
// next entry of a parametrised constant table into a one-slot output
// register. The index either wraps back to entry 0 or saturates on the last
// entry, selected by WRAP.
//
// Parameters:
//   DATA_WIDTH  width of one constant / of outs
//   DEPTH       number of table entries (>= 1)
//   CONSTS      packed table, entry i = CONSTS[i*DATA_WIDTH +: DATA_WIDTH]
//   WRAP        1: index wraps to 0 after the last entry, 0: index saturates
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   asynchronous reset, active low
//   bus   handshake bundle (slave side), see handshake_constant_seq_if
//
// Timing: one cycle latency, one token per cycle with outs_ready held high.
// The only combinational input-to-output path is outs_ready -> ctrl_ready.
// -----------------------------------------------------------------------------
module handshake_constant_seq #(
    parameter int                            DATA_WIDTH = 32,
    parameter int                            DEPTH      = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0]   CONSTS     = {(DEPTH*DATA_WIDTH){1'b0}},
    parameter bit                            WRAP       = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    handshake_constant_seq_if.slave  bus
);

    // Index register is at least one bit wide so DEPTH=1 still has a
    // legal (constant zero) index.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Registered state and next-state values
    logic                  full_q,  full_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  last_q,  last_d;

    // Combinational helpers
    logic                  accept_s;
    logic                  drain_s;
    logic [DATA_WIDTH-1:0] entry_s;
    logic                  entry_last_s;
    logic                  ctrl_ready_s;
    logic                  outs_valid_s;

    // Table lookup: AND-OR mux over all entries, so any DEPTH (not only
    // powers of two) selects cleanly without out-of-range indexing.
    always_comb begin
        entry_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            entry_s = entry_s |
                      (CONSTS[i*DATA_WIDTH +: DATA_WIDTH] &
                       {DATA_WIDTH{idx_q == IDX_W'(i)}});
        end
        entry_last_s = (idx_q == LAST_IDX);
    end

    // Output decode: valid is the slot flag, ready opens whenever the slot is
    // empty or is being emptied in this same cycle (no bubble on refill).
    always_comb begin
        outs_valid_s = full_q;
        ctrl_ready_s = (!full_q) || bus.outs_ready;
    end

    // Handshake qualifiers derived from the output decode
    always_comb begin
        accept_s = bus.ctrl_valid && ctrl_ready_s;
        drain_s  = full_q && bus.outs_ready;
    end

    // Next-state logic: load on accept, clear the slot on a pure drain,
    // otherwise hold everything (this also covers the stall case).
    always_comb begin
        full_d = full_q;
        idx_d  = idx_q;
        data_d = data_q;
        last_d = last_q;
        if (accept_s) begin
            full_d = 1'b1;
            data_d = entry_s;
            last_d = entry_last_s;
            if (entry_last_s) begin
                // On the last entry: wrap to 0, or saturate. With DEPTH=1
                // both choices keep the index at 0.
                idx_d = WRAP ? {IDX_W{1'b0}} : idx_q;
            end else begin
                idx_d = idx_q + IDX_ONE;
            end
        end else if (drain_s) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // State register with asynchronous active-low reset; reset discards any
    // in-flight token and restarts the sequence at entry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            idx_q  <= {IDX_W{1'b0}};
            data_q <= {DATA_WIDTH{1'b0}};
            last_q <= 1'b0;
        end else begin
            full_q <= full_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

    assign bus.ctrl_ready = ctrl_ready_s;
    assign bus.outs_valid = outs_valid_s;
    assign bus.outs       = data_q;
    assign bus.outs_last  = last_q;

endmodule

// File: tb/tb_handshake_constant_seq.sv
// -----------------------------------------------------------------------------
// tb_handshake_constant_seq
// Three instances share one stimulus stream: DEPTH=4/WRAP=1, DEPTH=4/WRAP=0
// and DEPTH=1 (constant 0xA5). The stimulus process predicts ctrl_ready and
// outs_valid, and on every predicted accept pushes the expected output token
// into a per-instance queue. A separate monitor pops and compares whenever an
// output token is consumed, and checks that outs is stable under stall.
// -----------------------------------------------------------------------------
module tb_handshake_constant_seq;

    localparam int DW = 8;
    localparam int NI = 3;
    localparam int          DEP [NI] = '{4, 4, 1};
    localparam bit          WRP [NI] = '{1'b1, 1'b0, 1'b1};
    localparam logic [7:0]  TBL [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};

    logic clk;
    logic rst;
    logic cv;
    logic ordy;

    handshake_constant_seq_if #(.DATA_WIDTH(DW)) if_w ();
    handshake_constant_seq_if #(.DATA_WIDTH(DW)) if_s ();
    handshake_constant_seq_if #(.DATA_WIDTH(DW)) if_1 ();

    assign if_w.ctrl_valid = cv;
    assign if_s.ctrl_valid = cv;
    assign if_1.ctrl_valid = cv;
    assign if_w.outs_ready = ordy;
    assign if_s.outs_ready = ordy;
    assign if_1.outs_ready = ordy;

    handshake_constant_seq #(
        .DATA_WIDTH(DW), .DEPTH(4), .CONSTS(32'h44332211), .WRAP(1'b1)
    ) dut_w (.clk(clk), .rst(rst), .bus(if_w));

    handshake_constant_seq #(
        .DATA_WIDTH(DW), .DEPTH(4), .CONSTS(32'h44332211), .WRAP(1'b0)
    ) dut_s (.clk(clk), .rst(rst), .bus(if_s));

    handshake_constant_seq #(
        .DATA_WIDTH(DW), .DEPTH(1), .CONSTS(8'hA5), .WRAP(1'b1)
    ) dut_1 (.clk(clk), .rst(rst), .bus(if_1));

    logic [7:0] outs_a  [NI];
    logic       last_a  [NI];
    logic       valid_a [NI];
    logic       ready_a [NI];

    assign outs_a[0] = if_w.outs;       assign outs_a[1] = if_s.outs;       assign outs_a[2] = if_1.outs;
    assign last_a[0] = if_w.outs_last;  assign last_a[1] = if_s.outs_last;  assign last_a[2] = if_1.outs_last;
    assign valid_a[0] = if_w.outs_valid; assign valid_a[1] = if_s.outs_valid; assign valid_a[2] = if_1.outs_valid;
    assign ready_a[0] = if_w.ctrl_ready; assign ready_a[1] = if_s.ctrl_ready; assign ready_a[2] = if_1.ctrl_ready;

    // Scoreboard / model state
    logic [8:0] exp_q [NI][$];   // {last, data}
    int  acc_n [NI];             // tokens accepted since last reset
    bit  mfull [NI];             // model of "an output token is pending"
    int  n_pass;
    int  n_total;
    int  rst_count;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: the n-th token since reset emits entry n mod DEPTH (wrap)
    // or min(n, DEPTH-1) (saturate); last flag marks entry DEPTH-1.
    function automatic logic [8:0] model_entry(input int k, input int n);
        int d;
        int e;
        logic [7:0] v;
        d = DEP[k];
        if (WRP[k]) e = n % d;
        else        e = (n < d - 1) ? n : d - 1;
        v = (d == 1) ? 8'hA5 : TBL[e];
        return {(e == d - 1), v};
    endfunction

    // One clock cycle of stimulus: drive at negedge, predict just after.
    task automatic cycle(input bit c, input bit r);
        bit exp_rdy;
        bit acc;
        @(negedge clk);
        cv   = c;
        ordy = r;
        #1;
        for (int k = 0; k < NI; k++) begin
            exp_rdy = !mfull[k] || r;
            check($sformatf("ctrl_ready[%0d]", k), 32'(ready_a[k]), 32'(exp_rdy));
            check($sformatf("outs_valid[%0d]", k), 32'(valid_a[k]), 32'(mfull[k]));
            acc = c && exp_rdy;
            if (acc) begin
                exp_q[k].push_back(model_entry(k, acc_n[k]));
                acc_n[k]++;
            end
            mfull[k] = acc ? 1'b1 : ((mfull[k] && r) ? 1'b0 : mfull[k]);
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_outs_valid[%0d]", tag, k), 32'(valid_a[k]), 32'd0);
            check($sformatf("%s_outs[%0d]", tag, k),       32'(outs_a[k]),  32'd0);
            check($sformatf("%s_outs_last[%0d]", tag, k),  32'(last_a[k]),  32'd0);
            check($sformatf("%s_ctrl_ready[%0d]", tag, k), 32'(ready_a[k]), 32'd1);
        end
    endtask

    // Asynchronous reset pulse in the middle of a cycle, away from any edge.
    task automatic reset_pulse();
        @(negedge clk);
        cv   = 1'b0;
        ordy = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        for (int k = 0; k < NI; k++) begin
            exp_q[k].delete();
            acc_n[k] = 0;
            mfull[k] = 1'b0;
        end
        rst_count++;
        #1;
        rst = 1'b1;
    endtask

    // Monitor: consume expected tokens on every output handshake and check
    // stall stability of the output register.
    initial begin
        int         seen;
        bit         ps [NI];
        logic [7:0] pd [NI];
        logic [8:0] e;
        seen = 0;
        for (int k = 0; k < NI; k++) begin
            ps[k] = 1'b0;
            pd[k] = 8'h00;
        end
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < NI; k++) begin
                if (ps[k] && (seen == rst_count)) begin
                    check($sformatf("stall_valid[%0d]", k), 32'(valid_a[k]), 32'd1);
                    check($sformatf("stall_outs[%0d]", k),  32'(outs_a[k]),  32'(pd[k]));
                end
                if (valid_a[k] && ordy) begin
                    check($sformatf("token_expected[%0d]", k), 32'(exp_q[k].size() > 0), 32'd1);
                    if (exp_q[k].size() > 0) begin
                        e = exp_q[k].pop_front();
                        check($sformatf("outs[%0d]", k),      32'(outs_a[k]), 32'(e[7:0]));
                        check($sformatf("outs_last[%0d]", k), 32'(last_a[k]), 32'(e[8]));
                    end
                end
                ps[k] = valid_a[k] && !ordy;
                pd[k] = outs_a[k];
            end
            seen = rst_count;
        end
    end

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_count = 0;
        for (int k = 0; k < NI; k++) begin
            acc_n[k] = 0;
            mfull[k] = 1'b0;
        end
        cv   = 1'b0;
        ordy = 1'b0;
        rst  = 1'b0;
        #2;
        check_reset_values("por");
        #1;
        rst = 1'b1;

        // Streaming: one token per cycle, no bubbles
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1);

        // Reset while a token is pending, sequence restarts at entry 0
        reset_pulse();

        // Backpressure: first token out, then stall 3 cycles, then release
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);

        // Reset mid-stream after two tokens, then one more token
        reset_pulse();
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        reset_pulse();
        cycle(1'b1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Drain
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        @(negedge clk);
        #3;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("final_queue_empty[%0d]", k), 32'(exp_q[k].size()), 32'd0);
            check($sformatf("final_outs_valid[%0d]", k),  32'(valid_a[k]),      32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/handshake_constant_seq.md
# handshake_constant_seq

Elastic constant-sequence source for the Dynamatic-generated dataflow netlist. It replaces a single hard-wired constant with a parametrised table of DEPTH constants. Each accepted control token emits the next table entry on a registered output channel. It sits wherever a loop or switch-case body needs a per-iteration constant (coefficient tables, breakpoints) fed from a control token.

## Interface
- DATA_WIDTH, 32: width of each constant and of `outs`.
- DEPTH, 4: number of table entries, ≥1.
- CONSTS, 0: packed table, DEPTH*DATA_WIDTH bits; entry i = CONSTS[i*DATA_WIDTH +: DATA_WIDTH].
- WRAP, 1: 1 = index wraps to 0 after entry DEPTH-1; 0 = index saturates at DEPTH-1.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- ctrl_valid  in  1  control token present.
- ctrl_ready  out  1  control token accepted this cycle when high with ctrl_valid.
- outs  out  DATA_WIDTH  current table entry (registered).
- outs_last  out  1  high when `outs` holds entry DEPTH-1.
- outs_valid  out  1  output token present.
- outs_ready  in  1  consumer accepts output token.

## Operation
- State:
  - `full` (1 bit), the output-register valid flag.
  - `idx`, index register of width max(1, clog2(DEPTH)).
  - Output data register and `outs_last` register.
- Reset (rst=0, immediate, no clock needed):
  - full=0, idx=0, outs=0, outs_last=0.
  - Consequently outs_valid=0.
  - ctrl_ready follows its combinational equation and is 1 during reset.
- outs_valid = full.
- ctrl_ready = !full || outs_ready. This is a one-slot pipeline register; the outs_ready→ctrl_ready path is combinational.
- accept = ctrl_valid && ctrl_ready. On accept:
  - outs ← CONSTS entry idx.
  - outs_last ← (idx == DEPTH-1).
  - full ← 1.
  - idx advances. If idx < DEPTH-1, idx+1. If idx == DEPTH-1, 0 when WRAP=1, else unchanged.
- Drain: outs_valid && outs_ready && !accept → full ← 0; data registers hold their value.
- Accept and drain in the same cycle: the new entry replaces the old one, full stays 1, and no bubble is inserted.
- Stall: full && !outs_ready → ctrl_ready=0, and outs, outs_last, idx are all stable. outs and outs_valid must not change while stalled.
- DEPTH=1: idx is held at 0. Every token emits entry 0 with outs_last=1. The result is a registered single constant.
- WRAP=0 after saturation: every further token emits entry DEPTH-1 with outs_last=1.
- ctrl carries no data; only its handshake is consumed.
- Reset asserted mid-stream: the in-flight token is discarded and the sequence restarts at entry 0 after release.

## Timing
- Latency: 1 cycle. Accept at edge N → outs_valid=1 with the entry visible after edge N.
- Throughput: 1 token/cycle with outs_ready held high.
- No combinational path from ctrl_valid to any output.
- Only outs_ready→ctrl_ready is combinational.
- After rst release, the first accept can occur at the first rising edge.

## Test plan
Common setup: DATA_WIDTH=8, DEPTH=4, CONSTS={8'h44,8'h33,8'h22,8'h11} (entry0=0x11).
- **Reset values:** drive rst=0 mid-cycle with no clock. outs_valid=0, outs=0x00 and outs_last=0 immediately; ctrl_ready=1.
- **Streaming, WRAP=1:** hold ctrl_valid=1 and outs_ready=1 for 6 cycles. outs = 0x11, 0x22, 0x33, 0x44, 0x11, 0x22 on consecutive cycles. outs_last=1 only on 0x44. No bubbles.
- **Backpressure:** after the first token is out, hold outs_ready=0 for 3 cycles with ctrl_valid=1.
  - ctrl_ready=0, outs=0x11 stable, idx not advanced.
  - Release: the next emitted value is 0x22 in the same cycle that 0x11 drains.
- **Saturation, WRAP=0:** send 6 tokens. outs = 0x11, 0x22, 0x33, 0x44, 0x44, 0x44, with outs_last=1 on the last three.
- **Reset mid-stream:** emit 0x11 and 0x22, pulse rst=0 while outs_valid=1. outs_valid drops asynchronously; the next token after release emits 0x11.
- **DEPTH=1, CONSTS=8'hA5:** random ctrl_valid/outs_ready for 200 cycles. Every output token is 0xA5 with outs_last=1. Output count equals accepted control count.
